// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants, FSM state type and rotate helper for the pending encoder
package encoder_pkg;

  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Rotate right by s so that bit s of v lands at bit 0; a lowest-set-bit
  // search on the result is then an upward search starting at s with wrap.
  function automatic logic [7:0] rotate8(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] dbl;
    dbl = {v, v} >> s;
    return dbl[7:0];
  endfunction

endpackage

// File: rtl/prio_pick8.sv
// rtl/prio_pick8.sv - combinational 8-way priority pick searching upward from a start index
//
// Ports:
//   vec    in  8  candidate bits
//   start  in  3  first index to consider; search proceeds upward and wraps 7->0
//   idx    out 3  first set index found (0 when vec is empty)
//   any    out 1  vec has at least one bit set
module prio_pick8
  import encoder_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] start,
  output logic [2:0] idx,
  output logic       any
);

  logic [7:0] rot;
  logic [2:0] off;

  always_comb begin
    rot = rotate8(vec, start);
    off = '0;
    // Walk downward so the lowest set bit of the rotated vector wins.
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    idx = (vec == '0) ? 3'd0 : start + off;
    any = |vec;
  end

endmodule

// File: rtl/pending_encoder_8to3.sv
// rtl/pending_encoder_8to3.sv - captures request rising edges as pending flags and presents them one code at a time
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   en        in   1  allows a new presentation to start (capture is never blocked)
//   clr       in   1  synchronous flush of pending/valid/overflow
//   req       in   N  request lines; only 0->1 transitions are captured
//   code      out  W  index being presented
//   valid     out  1  code is valid
//   ready     in   1  consumer accepts code on valid & ready
//   pending   out  N  registered pending flags
//   overflow  out  1  sticky: an edge landed on an already pending bit
module pending_encoder_8to3 #(
  parameter int N       = 8,
  parameter int W       = 3,
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  import encoder_pkg::*;

  state_t       state, state_next;
  logic [N-1:0] req_q;
  logic [N-1:0] rise;
  logic [N-1:0] retire;
  logic [N-1:0] pending_upd;
  logic [N-1:0] pending_next;
  logic [N-1:0] cand;
  logic [W-1:0] code_next;
  logic [W-1:0] rr_ptr, rr_next;
  logic [W-1:0] pick_start;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         overflow_next;
  logic         handshake;

  assign valid = (state == PRESENT);

  prio_pick8 u_pick (
    .vec   (cand),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    rise      = req & ~req_q;
    handshake = (state == PRESENT) && ready;
    retire    = '0;
    if (handshake) retire[code] = 1'b1;

    // Set wins over retire on the same bit, so OR the rise in last.
    pending_upd = (pending & ~retire) | rise;

    // The IDLE pick sees only registered flags (same-cycle edges excluded);
    // a back-to-back pick sees the updated flags minus the bit just retired.
    cand = (state == PRESENT) ? (pending_upd & ~retire) : pending;

    // In round-robin the search after a handshake starts just past the
    // retired code, which is exactly what rr_ptr becomes on that edge.
    if (RR_MODE != 0) begin
      pick_start = (state == PRESENT) ? code + 1'b1 : rr_ptr;
    end else begin
      pick_start = '0;
    end

    pending_next  = clr ? '0 : pending_upd;
    overflow_next = clr ? 1'b0 : (overflow | (|(rise & pending & ~retire)));
    state_next    = state;
    code_next     = code;
    rr_next       = rr_ptr;

    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            state_next = PRESENT;
            code_next  = pick_idx;
          end
        end
        PRESENT: begin
          if (handshake) begin
            if (RR_MODE != 0) rr_next = code + 1'b1;
            if (en && pick_any) begin
              code_next = pick_idx;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= '0;
      pending  <= '0;
      code     <= '0;
      rr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      req_q    <= req;
      pending  <= pending_next;
      code     <= code_next;
      rr_ptr   <= rr_next;
      overflow <= overflow_next;
    end
  end

endmodule

// File: tb/tb_pending_encoder_8to3.sv
// tb/tb_pending_encoder_8to3.sv - self-checking bench for pending_encoder_8to3 (fixed and round-robin)
module tb_pending_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [7:0] req;
  logic       ready;

  logic [2:0] code_f, code_r;
  logic       valid_f, valid_r;
  logic [7:0] pend_f, pend_r;
  logic       ovf_f, ovf_r;

  int n_chk  = 0;
  int n_pass = 0;

  pending_encoder_8to3 #(.N(8), .W(3), .RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req),
    .code(code_f), .valid(valid_f), .ready(ready), .pending(pend_f), .overflow(ovf_f)
  );

  pending_encoder_8to3 #(.N(8), .W(3), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .req(req),
    .code(code_r), .valid(valid_r), .ready(ready), .pending(pend_r), .overflow(ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-mode arrays, mode 0 fixed priority, mode 1 round-robin.
  bit m_pend [2][8];
  bit m_valid[2];
  int m_code [2];
  bit m_ovf  [2];
  int m_ptr  [2];
  bit m_reqq [8];

  function automatic int search(input bit v[8], input int start);
    for (int k = 0; k < 8; k++) begin
      if (v[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pack(input bit v[8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) m_pend[m][i] = 0;
      m_valid[m] = 0; m_code[m] = 0; m_ovf[m] = 0; m_ptr[m] = 0;
    end
    for (int i = 0; i < 8; i++) m_reqq[i] = 0;
  endtask

  task automatic model_step();
    bit rise[8];
    for (int i = 0; i < 8; i++) rise[i] = req[i] && !m_reqq[i];
    for (int m = 0; m < 2; m++) begin
      bit old[8], nxt[8], cand[8];
      bit hs;
      int ret, p;
      hs  = m_valid[m] && ready;
      ret = hs ? m_code[m] : -1;
      old = m_pend[m];
      for (int i = 0; i < 8; i++) begin
        nxt[i]  = ((old[i] && i != ret) || rise[i]);
        cand[i] = nxt[i] && (i != ret);
        if (!clr && rise[i] && old[i] && i != ret) m_ovf[m] = 1;
      end
      if (clr) begin
        for (int i = 0; i < 8; i++) m_pend[m][i] = 0;
        m_valid[m] = 0;
        m_ovf[m]   = 0;
      end else begin
        m_pend[m] = nxt;
        if (!m_valid[m]) begin
          p = search(old, (m == 1) ? m_ptr[m] : 0);
          if (en && p >= 0) begin
            m_valid[m] = 1;
            m_code[m]  = p;
          end
        end else if (hs) begin
          if (m == 1) m_ptr[m] = (m_code[m] + 1) % 8;
          p = search(cand, (m == 1) ? (m_code[m] + 1) % 8 : 0);
          if (en && p >= 0) m_code[m] = p;
          else m_valid[m] = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) m_reqq[i] = req[i];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; req = '0; ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       en;
    logic       clr;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{8'h10, 1, 1, 0, 0, 3'd0, 8'h10, 0};
    tbl[1]  = '{8'h10, 1, 1, 0, 1, 3'd4, 8'h10, 0};
    tbl[2]  = '{8'h10, 1, 1, 0, 0, 3'd4, 8'h00, 0};
    tbl[3]  = '{8'hA4, 1, 1, 0, 0, 3'd4, 8'hA4, 0};
    tbl[4]  = '{8'hA4, 1, 1, 0, 1, 3'd2, 8'hA4, 0};
    tbl[5]  = '{8'hA4, 1, 1, 0, 1, 3'd5, 8'hA0, 0};
    tbl[6]  = '{8'hA4, 1, 1, 0, 1, 3'd7, 8'h80, 0};
    tbl[7]  = '{8'hA4, 1, 1, 0, 0, 3'd7, 8'h00, 0};
    tbl[8]  = '{8'h08, 0, 1, 0, 0, 3'd7, 8'h08, 0};
    tbl[9]  = '{8'h08, 0, 1, 0, 1, 3'd3, 8'h08, 0};
    tbl[10] = '{8'h00, 0, 1, 0, 1, 3'd3, 8'h08, 0};
    tbl[11] = '{8'h08, 0, 1, 0, 1, 3'd3, 8'h08, 1};
    tbl[12] = '{8'h08, 0, 1, 0, 1, 3'd3, 8'h08, 1};
    tbl[13] = '{8'h08, 0, 1, 0, 1, 3'd3, 8'h08, 1};
    tbl[14] = '{8'h08, 1, 1, 0, 0, 3'd3, 8'h00, 1};
    tbl[15] = '{8'h00, 0, 1, 1, 0, 3'd3, 8'h00, 0};
    tbl[16] = '{8'h40, 0, 1, 0, 0, 3'd3, 8'h40, 0};
    tbl[17] = '{8'h00, 0, 1, 0, 1, 3'd6, 8'h40, 0};
    tbl[18] = '{8'h40, 1, 1, 0, 0, 3'd6, 8'h40, 0};
    tbl[19] = '{8'h40, 1, 1, 0, 1, 3'd6, 8'h40, 0};
    tbl[20] = '{8'h40, 0, 1, 1, 0, 3'd6, 8'h00, 0};
    tbl[21] = '{8'h40, 0, 1, 0, 0, 3'd6, 8'h00, 0};
    tbl[22] = '{8'h01, 0, 0, 0, 0, 3'd6, 8'h01, 0};
    tbl[23] = '{8'h01, 0, 0, 0, 0, 3'd6, 8'h01, 0};
    tbl[24] = '{8'h01, 0, 1, 0, 1, 3'd0, 8'h01, 0};
    tbl[25] = '{8'h01, 1, 1, 0, 0, 3'd0, 8'h00, 0};

    do_reset();
    chk("reset_valid", {31'd0, valid_f}, 32'd0);
    chk("reset_pending", {24'd0, pend_f}, 32'd0);

    // Fixed-priority directed table
    for (int r = 0; r < 26; r++) begin
      req = tbl[r].req; ready = tbl[r].ready; en = tbl[r].en; clr = tbl[r].clr;
      tick();
      chk($sformatf("tbl%0d_valid", r), {31'd0, valid_f}, {31'd0, tbl[r].valid});
      if (tbl[r].valid) chk($sformatf("tbl%0d_code", r), {29'd0, code_f}, {29'd0, tbl[r].code});
      chk($sformatf("tbl%0d_pending", r), {24'd0, pend_f}, {24'd0, tbl[r].pend});
      chk($sformatf("tbl%0d_overflow", r), {31'd0, ovf_f}, {31'd0, tbl[r].ovf});
    end

    // Round-robin: all eight pending, back-to-back 0..7, then 0 again after wrap
    do_reset();
    en = 1'b1; ready = 1'b1; req = 8'hFF;
    tick();
    chk("rr_pending_all", {24'd0, pend_r}, 32'hFF);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr_code%0d", k), {28'd0, valid_r, code_r}, {28'd0, 1'b1, 3'(k)});
    end
    req = 8'hFE;
    tick();
    chk("rr_drain_valid", {31'd0, valid_r}, 32'd0);
    req = 8'hFF;
    tick();
    tick();
    chk("rr_wrap_code0", {28'd0, valid_r, code_r}, {28'd0, 1'b1, 3'd0});

    // Asynchronous reset mid-presentation, observed without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rr", {19'd0, code_r, valid_r, pend_r, ovf_r}, 32'd0);
    chk("async_rst_fix", {19'd0, code_f, valid_f, pend_f, ovf_f}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Randomized run against the reference model, both modes
    for (int c = 0; c < 600; c++) begin
      req   = 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 31) == 0);
      tick();
      chk($sformatf("rand%0d_fix", c), {19'd0, code_f, valid_f, pend_f, ovf_f},
          {19'd0, 3'(m_valid[0] ? m_code[0] : code_f), m_valid[0], pack(m_pend[0]), m_ovf[0]});
      chk($sformatf("rand%0d_rr", c), {19'd0, code_r, valid_r, pend_r, ovf_r},
          {19'd0, 3'(m_valid[1] ? m_code[1] : code_r), m_valid[1], pack(m_pend[1]), m_ovf[1]});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
